// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues mini-ALU commands and sequences them through an external combinational ALU
//
// Purpose: commands (fxn, a, b) are buffered in a DEPTH-entry FIFO. They are issued
// one at a time on registered alu_* outputs and held for SETTLE cycles. The ALU
// result is then captured and offered downstream on a valid/ready handshake.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_fxn/cmd_a/cmd_b payload
//   alu_fxn/alu_a/alu_b            registered operands driven to the ALU
//   alu_result                     ALU final_out
//   res_valid/res_ready            result handshake; res_data/res_fxn payload
//   busy                           sequencer active or commands queued
//   fifo_count                     queued commands, excluding the one in flight
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_fxn,
    input  logic [5:0]               cmd_a,
    input  logic [5:0]               cmd_b,
    output logic [2:0]               alu_fxn,
    output logic [5:0]               alu_a,
    output logic [5:0]               alu_b,
    input  logic [5:0]               alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [5:0]               res_data,
    output logic [2:0]               res_fxn,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [14:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [14:0]   head;
    logic [SW-1:0] settle_cnt;

    logic push, pop, capture, release_res;

    // No bypass: a full FIFO refuses even when the FSM pops in the same cycle.
    assign cmd_ready = (fifo_count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (settle_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    // Issue the next command on the same edge the result leaves.
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage array has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_fxn, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            alu_fxn    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_fxn    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                alu_fxn    <= head[14:12];
                alu_a      <= head[11:6];
                alu_b      <= head[5:0];
                settle_cnt <= SETTLE_LOAD;
            end else if (state == EXEC && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_result;
                res_fxn   <= alu_fxn;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
